// File: rtl/ram_read_arbiter_pkg.sv
// Shared encodings for the RAM read arbiter: FSM states and grant owner codes.
package ram_read_arbiter_pkg;

    localparam int unsigned RES_DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_IMEM = 2'b01,
        GRANT_DMEM = 2'b10
    } grant_e;

endpackage

// File: rtl/ram_read_arbiter.sv
// Two-port (imem/dmem) read arbiter in front of a single RAM read port.
// Define LEMON_ARB_STARVE_EN to let waiting dmem requests overtake imem after STARVE_LIMIT grants.
module ram_read_arbiter
    import ram_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imem_req_valid_i,
    input  logic [ADDR_W-1:0]     imem_req_addr_i,
    output logic                  imem_res_valid_o,
    output logic [RES_DATA_W-1:0] imem_res_data_o,
    input  logic                  dmem_req_valid_i,
    input  logic [ADDR_W-1:0]     dmem_req_addr_i,
    output logic                  dmem_res_valid_o,
    output logic [RES_DATA_W-1:0] dmem_res_data_o,
    output logic                  ram_read_req_valid_o,
    output logic [ADDR_W-1:0]     ram_read_req_addr_o,
    input  logic                  ram_read_res_valid_i,
    input  logic [RES_DATA_W-1:0] ram_read_res_data_i,
    output logic [1:0]            grant_o
);

    arb_state_e        state_q;
    grant_e            grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              drop_q;

    logic any_req;
    logic starved;
    logic pick_dmem;
    logic owner_valid;
    logic fwd;

    assign any_req = imem_req_valid_i | dmem_req_valid_i;

`ifdef LEMON_ARB_STARVE_EN
    logic [3:0] starve_q;

    assign starved = (starve_q == 4'(STARVE_LIMIT));

    // Counts imem wins taken while dmem was also waiting; any dmem win clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else if (state_q == ST_IDLE && any_req) begin
            if (pick_dmem) begin
                starve_q <= '0;
            end else if (dmem_req_valid_i && !starved) begin
                starve_q <= starve_q + 4'd1;
            end
        end
    end
`else
    assign starved = 1'b0;
`endif

    assign pick_dmem = dmem_req_valid_i & (~imem_req_valid_i | starved);

    always_comb begin
        owner_valid = 1'b0;
        case (grant_q)
            GRANT_IMEM: owner_valid = imem_req_valid_i;
            GRANT_DMEM: owner_valid = dmem_req_valid_i;
            default:    owner_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_NONE;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_BUSY;
                        grant_q <= pick_dmem ? GRANT_DMEM : GRANT_IMEM;
                        addr_q  <= pick_dmem ? dmem_req_addr_i : imem_req_addr_i;
                        drop_q  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Once the owner lets go, the in-flight read still completes but is never delivered.
                    if (!owner_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (ram_read_res_valid_i) begin
                        state_q <= ST_IDLE;
                        grant_q <= GRANT_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= GRANT_NONE;
                end
            endcase
        end
    end

    assign ram_read_req_valid_o = (state_q == ST_BUSY) & ~rst_i;
    assign ram_read_req_addr_o  = ram_read_req_valid_o ? addr_q : '0;

    // The response passes straight through so a combinational RAM gives single-cycle latency.
    assign fwd              = ram_read_req_valid_o & ram_read_res_valid_i & owner_valid & ~drop_q;
    assign imem_res_valid_o = fwd & (grant_q == GRANT_IMEM);
    assign dmem_res_valid_o = fwd & (grant_q == GRANT_DMEM);
    assign imem_res_data_o  = imem_res_valid_o ? ram_read_res_data_i : '0;
    assign dmem_res_data_o  = dmem_res_valid_o ? ram_read_res_data_i : '0;
    assign grant_o          = grant_q;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Self-checking bench for ram_read_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_ram_read_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int          LIMIT  = 4;
`ifdef LEMON_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_v = 1'b0;
    logic [ADDR_W-1:0] imem_a = '0;
    logic              imem_rv;
    logic [31:0]       imem_rd;
    logic              dmem_v = 1'b0;
    logic [ADDR_W-1:0] dmem_a = '0;
    logic              dmem_rv;
    logic [31:0]       dmem_rd;
    logic              ram_qv;
    logic [ADDR_W-1:0] ram_qa;
    logic              ram_rv = 1'b0;
    logic [31:0]       ram_rd = '0;
    logic [1:0]        grant;

    int checks = 0;
    int errors = 0;

    ram_read_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .imem_req_valid_i    (imem_v),
        .imem_req_addr_i     (imem_a),
        .imem_res_valid_o    (imem_rv),
        .imem_res_data_o     (imem_rd),
        .dmem_req_valid_i    (dmem_v),
        .dmem_req_addr_i     (dmem_a),
        .dmem_res_valid_o    (dmem_rv),
        .dmem_res_data_o     (dmem_rd),
        .ram_read_req_valid_o(ram_qv),
        .ram_read_req_addr_o (ram_qa),
        .ram_read_res_valid_i(ram_rv),
        .ram_read_res_data_i (ram_rd),
        .grant_o             (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Transaction-level model: who owns the RAM, which address, whether the owner gave up,
    // and how many imem wins in a row dmem has been passed over.
    bit          model_ok = 1'b0;
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    logic [31:0] m_addr = '0;
    bit          m_abandoned = 1'b0;
    int          m_streak = 0;
    int          glog[$];
    bit          last_i_res = 1'b0;
    bit          last_d_res = 1'b0;
    bit          auto_ram = 1'b0;

    always @(negedge clk) begin
        bit          e_req;
        bit          ov;
        bit          e_fwd;
        int          win;
        ov = (m_owner == 1) ? imem_v : (m_owner == 2) ? dmem_v : 1'b0;
        if (model_ok) begin
            e_req = m_busy && !rst;
            e_fwd = e_req && ram_rv && ov && !m_abandoned;
            check("ram_req_valid", 64'(ram_qv), 64'(e_req));
            check("ram_req_addr", 64'(ram_qa), e_req ? 64'(m_addr) : 64'd0);
            check("grant", 64'(grant), 64'(m_owner));
            check("imem_res_valid", 64'(imem_rv), 64'(e_fwd && m_owner == 1));
            check("imem_res_data", 64'(imem_rd), (e_fwd && m_owner == 1) ? 64'(ram_rd) : 64'd0);
            check("dmem_res_valid", 64'(dmem_rv), 64'(e_fwd && m_owner == 2));
            check("dmem_res_data", 64'(dmem_rd), (e_fwd && m_owner == 2) ? 64'(ram_rd) : 64'd0);
        end
        last_i_res = (imem_rv === 1'b1);
        last_d_res = (dmem_rv === 1'b1);
        if (imem_rv === 1'b1) glog.push_back(1);
        if (dmem_rv === 1'b1) glog.push_back(2);

        if (rst) begin
            model_ok = 1'b1;
            m_busy = 1'b0; m_owner = 0; m_addr = '0; m_abandoned = 1'b0; m_streak = 0;
        end else if (!m_busy) begin
            if (imem_v || dmem_v) begin
                if (imem_v && dmem_v) win = (STARVE && m_streak >= LIMIT) ? 2 : 1;
                else                  win = imem_v ? 1 : 2;
                if (STARVE) begin
                    if (win == 2)    m_streak = 0;
                    else if (dmem_v) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
                end
                m_busy = 1'b1;
                m_owner = win;
                m_addr = (win == 1) ? imem_a : dmem_a;
                m_abandoned = 1'b0;
            end
        end else begin
            if (!ov) m_abandoned = 1'b1;
            if (ram_rv) begin
                m_busy = 1'b0;
                m_owner = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ram) begin
            ram_rv = ram_qv;
            ram_rd = $urandom;
        end
    endtask

    task automatic do_reset();
        auto_ram = 1'b0;
        rst = 1'b1; imem_v = 1'b0; dmem_v = 1'b0; ram_rv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int expd[10];
        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_ram_valid", 64'(ram_qv), 64'd0);

        // imem only, single-cycle RAM
        tick();
        imem_v = 1'b1; imem_a = 32'h100;
        @(negedge clk);
        check("idle_no_ram_req", 64'(ram_qv), 64'd0);
        tick();
        ram_rv = 1'b1; ram_rd = 32'hDEADBEEF;
        @(negedge clk);
        check("s1_ram_addr", 64'(ram_qa), 64'h100);
        check("s1_imem_valid", 64'(imem_rv), 64'd1);
        check("s1_imem_data", 64'(imem_rd), 64'hDEADBEEF);
        check("s1_dmem_valid", 64'(dmem_rv), 64'd0);
        check("s1_dmem_data", 64'(dmem_rd), 64'd0);
        tick();
        imem_v = 1'b0; ram_rv = 1'b0;
        @(negedge clk);
        check("s1_grant_after", 64'(grant), 64'd0);

        // dmem abandons while RAM stalls
        do_reset();
        dmem_v = 1'b1; dmem_a = 32'h2000;
        tick();
        dmem_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4_stall_valid", 64'(ram_qv), 64'd1);
            check("s4_stall_addr", 64'(ram_qa), 64'h2000);
            tick();
        end
        ram_rv = 1'b1; ram_rd = 32'hCAFE0001;
        @(negedge clk);
        check("s4_no_imem_res", 64'(imem_rv), 64'd0);
        check("s4_no_dmem_res", 64'(dmem_rv), 64'd0);
        tick();
        ram_rv = 1'b0;
        @(negedge clk);
        check("s4_idle_grant", 64'(grant), 64'd0);
        check("s4_idle_ram", 64'(ram_qv), 64'd0);

        // Stray RAM response in IDLE
        tick();
        ram_rv = 1'b1; ram_rd = 32'h1234;
        @(negedge clk);
        check("stray_imem", 64'(imem_rv), 64'd0);
        check("stray_dmem", 64'(dmem_rv), 64'd0);
        tick();
        ram_rv = 1'b0;

        // Build up some starvation history, then reset mid-transaction
        do_reset();
        glog.delete();
        imem_v = 1'b1; dmem_v = 1'b1; imem_a = 32'h40; dmem_a = 32'h80;
        auto_ram = 1'b1;
        for (int i = 0; i < 40 && glog.size() < 2; i++) begin
            tick();
            @(negedge clk);
        end
        check("s5_prefix_count", 64'(glog.size()), 64'd2);
        auto_ram = 1'b0;
        tick();
        ram_rv = 1'b0;
        tick();
        @(negedge clk);
        check("s5_busy", 64'(ram_qv), 64'd1);
        tick();
        rst = 1'b1; imem_v = 1'b0; dmem_v = 1'b0;
        @(negedge clk);
        check("s5_rst_ram_valid", 64'(ram_qv), 64'd0);
        check("s5_rst_ram_addr", 64'(ram_qa), 64'd0);
        tick();
        rst = 1'b0; ram_rv = 1'b1; ram_rd = 32'h55;
        @(negedge clk);
        check("s5_no_imem_res", 64'(imem_rv), 64'd0);
        check("s5_no_dmem_res", 64'(dmem_rv), 64'd0);
        check("s5_grant", 64'(grant), 64'd0);
        tick();
        ram_rv = 1'b0;

        // Both requesters held: starvation pattern (also shows the counter restarted at 0)
        glog.delete();
        imem_v = 1'b1; dmem_v = 1'b1;
        auto_ram = 1'b1;
        for (int i = 0; i < 80 && glog.size() < 10; i++) begin
            tick();
            @(negedge clk);
        end
        auto_ram = 1'b0;
        tick();
        imem_v = 1'b0; dmem_v = 1'b0; ram_rv = 1'b0;
        for (int i = 0; i < 10; i++) expd[i] = (STARVE && (i == 4 || i == 9)) ? 2 : 1;
        check("s2_count", 64'(glog.size()), 64'd10);
        for (int i = 0; i < 10 && i < glog.size(); i++) check("s2_grant_seq", 64'(glog[i]), 64'(expd[i]));

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (last_i_res) imem_v = 1'b0;
            else if (!imem_v && $urandom_range(0, 2) == 0) begin
                imem_v = 1'b1; imem_a = $urandom;
            end else if (imem_v && $urandom_range(0, 49) == 0) imem_v = 1'b0;
            if (last_d_res) dmem_v = 1'b0;
            else if (!dmem_v && $urandom_range(0, 2) == 0) begin
                dmem_v = 1'b1; dmem_a = $urandom;
            end else if (dmem_v && $urandom_range(0, 49) == 0) dmem_v = 1'b0;
            ram_rv = ($urandom_range(0, 2) == 0);
            ram_rd = $urandom;
        end
        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
